// File: rtl/tetris_move_scheduler.sv
// Frame-paced arbiter that turns key levels, auto-repeat and gravity into one board command at a
// time over a valid/ready/done handshake, including the lock/spawn/game-over sequence.
module tetris_move_scheduler #(
  parameter int unsigned GRAVITY_FRAMES   = 48,
  parameter int unsigned REPEAT_DELAY     = 16,
  parameter int unsigned REPEAT_RATE      = 4,
  parameter int unsigned SOFT_DROP_FRAMES = 2
) (
  input  logic       I_50MHZ_CLK,
  input  logic       I_RESET,
  input  logic       I_KEY_UP,
  input  logic       I_KEY_DOWN,
  input  logic       I_KEY_LEFT,
  input  logic       I_KEY_RIGHT,
  input  logic       I_FRAME_TICK,
  input  logic [3:0] I_LEVEL,
  output logic       O_CMD_VALID,
  output logic [2:0] O_CMD,
  input  logic       I_CMD_READY,
  input  logic       I_CMD_DONE,
  input  logic       I_CMD_BLOCKED,
  output logic       O_BUSY,
  output logic       O_GAME_OVER
);

  localparam logic [2:0] CmdLeft   = 3'd1;
  localparam logic [2:0] CmdRight  = 3'd2;
  localparam logic [2:0] CmdRotate = 3'd3;
  localparam logic [2:0] CmdSoft   = 3'd4;
  localparam logic [2:0] CmdGrav   = 3'd5;
  localparam logic [2:0] CmdLock   = 3'd6;
  localparam logic [2:0] CmdSpawn  = 3'd7;

  localparam logic [7:0] RptDelay   = 8'(REPEAT_DELAY);
  localparam logic [7:0] RptReload  = 8'(REPEAT_DELAY + REPEAT_RATE);
  localparam logic [7:0] SoftPeriod = 8'(SOFT_DROP_FRAMES);
  localparam logic [8:0] GravBase   = 9'(GRAVITY_FRAMES);

  // Pending-flag bit positions
  localparam int unsigned FRot   = 0;
  localparam int unsigned FLeft  = 1;
  localparam int unsigned FRight = 2;
  localparam int unsigned FSoft  = 3;
  localparam int unsigned FGrav  = 4;

  typedef enum logic [2:0] {
    StIdle, StIssue, StWait, StLockIssue, StLockWait, StSpawnIssue, StSpawnWait, StOver
  } state_e;

  state_e          state_q, state_d;
  logic [3:0]      sync1_q, sync2_q, prev_q;  // {up, down, left, right}
  logic [3:0]      key_rise;
  logic            both_lr, frame_adv;
  logic [1:0][7:0] rpt_cnt_q, rpt_cnt_d, rpt_inc;  // [1] left, [0] right
  logic [1:0]      rpt_fire;
  logic [7:0]      soft_cnt_q, soft_cnt_d, soft_inc;
  logic            soft_fire;
  logic [7:0]      grav_cnt_q, grav_cnt_d, grav_inc, grav_period;
  logic [8:0]      level_x4;
  logic            grav_fire, grav_clr;
  logic [4:0]      pend_q, pend_d, events, done_mask;
  logic            valid_q, busy_q, over_q;
  logic [2:0]      cmd_q, cmd_d, pick;

  assign key_rise  = sync2_q & ~prev_q;
  assign both_lr   = sync2_q[1] & sync2_q[0];
  assign frame_adv = I_FRAME_TICK && (state_q != StOver);

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      rpt_inc[i]   = rpt_cnt_q[i] + 8'd1;
      rpt_cnt_d[i] = rpt_cnt_q[i];
      rpt_fire[i]  = 1'b0;
      if (!sync2_q[i] || both_lr) begin
        rpt_cnt_d[i] = '0;
      end else if (frame_adv) begin
        // Reload to the delay point so later repeats fall every RATE frames
        if (rpt_inc[i] == RptReload) begin
          rpt_cnt_d[i] = RptDelay;
          rpt_fire[i]  = 1'b1;
        end else begin
          rpt_cnt_d[i] = rpt_inc[i];
          rpt_fire[i]  = (rpt_inc[i] == RptDelay);
        end
      end
    end
  end

  always_comb begin
    soft_inc   = soft_cnt_q + 8'd1;
    soft_cnt_d = soft_cnt_q;
    soft_fire  = 1'b0;
    if (!sync2_q[2]) begin
      soft_cnt_d = '0;
    end else if (frame_adv) begin
      if (soft_inc == SoftPeriod) begin
        soft_cnt_d = '0;
        soft_fire  = 1'b1;
      end else begin
        soft_cnt_d = soft_inc;
      end
    end
  end

  always_comb begin
    level_x4    = {3'b000, I_LEVEL, 2'b00};
    grav_period = (GravBase > level_x4) ? 8'(GravBase - level_x4) : 8'd1;
    grav_inc    = grav_cnt_q + 8'd1;
    grav_cnt_d  = grav_cnt_q;
    grav_fire   = 1'b0;
    if (frame_adv) begin
      if (grav_inc >= grav_period) begin
        grav_fire  = 1'b1;
        grav_cnt_d = '0;
      end else begin
        grav_cnt_d = grav_inc;
      end
    end
    if (grav_clr) grav_cnt_d = '0;
  end

  always_comb begin
    events = '0;
    if (state_q != StOver) begin
      events[FRot]   = key_rise[3];
      events[FLeft]  = (key_rise[1] & ~both_lr) | rpt_fire[1];
      events[FRight] = (key_rise[0] & ~both_lr) | rpt_fire[0];
      events[FSoft]  = key_rise[2] | soft_fire;
      events[FGrav]  = grav_fire;
    end
    done_mask = '0;
    if (state_q == StWait && I_CMD_DONE) begin
      case (cmd_q)
        CmdRotate: done_mask[FRot]   = 1'b1;
        CmdLeft:   done_mask[FLeft]  = 1'b1;
        CmdRight:  done_mask[FRight] = 1'b1;
        CmdSoft:   done_mask[FSoft]  = 1'b1;
        CmdGrav:   done_mask[FGrav]  = 1'b1;
        default:   done_mask = '0;
      endcase
    end
    pend_d = (pend_q & ~done_mask) | events;
    if (state_q == StWait && state_d == StLockIssue) pend_d = '0;
  end

  always_comb begin
    if (pend_q[FRot])        pick = CmdRotate;
    else if (pend_q[FLeft])  pick = CmdLeft;
    else if (pend_q[FRight]) pick = CmdRight;
    else if (pend_q[FSoft])  pick = CmdSoft;
    else                     pick = CmdGrav;
  end

  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    grav_clr = 1'b0;
    case (state_q)
      StIdle: begin
        if (|pend_q) begin
          state_d = StIssue;
          cmd_d   = pick;
        end
      end
      StIssue: if (valid_q && I_CMD_READY) state_d = StWait;
      StWait: begin
        if (I_CMD_DONE) begin
          if ((cmd_q == CmdSoft || cmd_q == CmdGrav) && I_CMD_BLOCKED) begin
            state_d = StLockIssue;
            cmd_d   = CmdLock;
          end else begin
            state_d  = StIdle;
            grav_clr = (cmd_q == CmdSoft);
          end
        end
      end
      StLockIssue: if (valid_q && I_CMD_READY) state_d = StLockWait;
      StLockWait: begin
        if (I_CMD_DONE) begin
          state_d = StSpawnIssue;
          cmd_d   = CmdSpawn;
        end
      end
      StSpawnIssue: begin
        cmd_d = CmdSpawn;
        if (valid_q && I_CMD_READY) state_d = StSpawnWait;
      end
      StSpawnWait: begin
        if (I_CMD_DONE) begin
          if (I_CMD_BLOCKED) begin
            state_d = StOver;
          end else begin
            state_d  = StIdle;
            grav_clr = 1'b1;
          end
        end
      end
      StOver:  state_d = StOver;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge I_50MHZ_CLK) begin
    if (!I_RESET) begin
      state_q    <= StSpawnIssue;
      sync1_q    <= '0;
      sync2_q    <= '0;
      prev_q     <= '0;
      rpt_cnt_q  <= '0;
      soft_cnt_q <= '0;
      grav_cnt_q <= '0;
      pend_q     <= '0;
      valid_q    <= 1'b0;
      cmd_q      <= '0;
      busy_q     <= 1'b0;
      over_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync1_q    <= {I_KEY_UP, I_KEY_DOWN, I_KEY_LEFT, I_KEY_RIGHT};
      sync2_q    <= sync1_q;
      prev_q     <= sync2_q;
      rpt_cnt_q  <= rpt_cnt_d;
      soft_cnt_q <= soft_cnt_d;
      grav_cnt_q <= grav_cnt_d;
      pend_q     <= pend_d;
      valid_q    <= (state_d == StIssue) || (state_d == StLockIssue) || (state_d == StSpawnIssue);
      cmd_q      <= cmd_d;
      busy_q     <= (state_d != StIdle) && (state_d != StOver);
      over_q     <= (state_d == StOver);
    end
  end

  assign O_CMD_VALID = valid_q;
  assign O_CMD       = cmd_q;
  assign O_BUSY      = busy_q;
  assign O_GAME_OVER = over_q;

endmodule

// File: tb/tb_tetris_move_scheduler.sv
// Bench for tetris_move_scheduler: a board responder pops an expected-command scoreboard at every
// handshake, while the main sequence drives keys, frame ticks, blocking and resets.
module tb_tetris_move_scheduler;

  localparam logic [2:0] CLeft  = 3'd1;
  localparam logic [2:0] CRight = 3'd2;
  localparam logic [2:0] CRot   = 3'd3;
  localparam logic [2:0] CSoft  = 3'd4;
  localparam logic [2:0] CGrav  = 3'd5;
  localparam logic [2:0] CLock  = 3'd6;
  localparam logic [2:0] CSpawn = 3'd7;

  typedef struct {
    logic [3:0]  level;
    int unsigned period;
  } grav_vec_t;

  logic       clk = 1'b0;
  logic       I_RESET, I_KEY_UP, I_KEY_DOWN, I_KEY_LEFT, I_KEY_RIGHT, I_FRAME_TICK;
  logic [3:0] I_LEVEL;
  logic       O_CMD_VALID;
  logic [2:0] O_CMD;
  logic       I_CMD_READY, I_CMD_DONE, I_CMD_BLOCKED, O_BUSY, O_GAME_OVER;

  int         checks;
  int         errors;
  logic [2:0] exp_q[$];
  logic       hold_done;
  logic [7:0] block_mask;
  grav_vec_t  vecs[6];

  always #5 clk = ~clk;

  tetris_move_scheduler dut (
    .I_50MHZ_CLK  (clk),
    .I_RESET      (I_RESET),
    .I_KEY_UP     (I_KEY_UP),
    .I_KEY_DOWN   (I_KEY_DOWN),
    .I_KEY_LEFT   (I_KEY_LEFT),
    .I_KEY_RIGHT  (I_KEY_RIGHT),
    .I_FRAME_TICK (I_FRAME_TICK),
    .I_LEVEL      (I_LEVEL),
    .O_CMD_VALID  (O_CMD_VALID),
    .O_CMD        (O_CMD),
    .I_CMD_READY  (I_CMD_READY),
    .I_CMD_DONE   (I_CMD_DONE),
    .I_CMD_BLOCKED(I_CMD_BLOCKED),
    .O_BUSY       (O_BUSY),
    .O_GAME_OVER  (O_GAME_OVER)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    I_FRAME_TICK = 1'b1;
    step();
    I_FRAME_TICK = 1'b0;
    repeat (9) step();
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic wait_empty(input string name, input int budget);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    check(name, 32'(ok), 32'd1);
  endtask

  task automatic wait_idle(input string name, input int budget);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (exp_q.size() == 0 && !O_BUSY && !O_CMD_VALID) begin
        ok = 1'b1;
        break;
      end
    end
    check(name, 32'(ok), 32'd1);
  endtask

  // Board model: accepts at once, answers DONE the cycle after the handshake unless held.
  task automatic board_model();
    logic outstanding;
    logic blk;
    outstanding = 1'b0;
    blk         = 1'b0;
    forever begin
      @(negedge clk);
      I_CMD_DONE    = 1'b0;
      I_CMD_BLOCKED = 1'b0;
      if (outstanding && !hold_done) begin
        I_CMD_DONE    = 1'b1;
        I_CMD_BLOCKED = blk;
        outstanding   = 1'b0;
      end
      if (O_CMD_VALID && I_CMD_READY) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_cmd actual=%0d required=none", O_CMD);
        end else begin
          check("cmd_order", 32'(O_CMD), 32'(exp_q.pop_front()));
        end
        blk         = block_mask[O_CMD];
        outstanding = 1'b1;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    checks = 0;  errors = 0;
    hold_done = 1'b0;  block_mask = '0;
    I_RESET = 1'b0;  I_KEY_UP = 1'b0;  I_KEY_DOWN = 1'b0;  I_KEY_LEFT = 1'b0;  I_KEY_RIGHT = 1'b0;
    I_FRAME_TICK = 1'b0;  I_LEVEL = 4'd0;
    I_CMD_READY = 1'b1;  I_CMD_DONE = 1'b0;  I_CMD_BLOCKED = 1'b0;
    vecs[0] = '{4'd0, 48};
    vecs[1] = '{4'd1, 44};
    vecs[2] = '{4'd5, 28};
    vecs[3] = '{4'd11, 4};
    vecs[4] = '{4'd12, 1};
    vecs[5] = '{4'd15, 1};
    fork
      board_model();
    join_none

    // Reset values, then the first piece spawns on its own
    repeat (3) step();
    check("rst_valid", 32'(O_CMD_VALID), 32'd0);
    check("rst_cmd", 32'(O_CMD), 32'd0);
    check("rst_over", 32'(O_GAME_OVER), 32'd0);
    check("rst_busy", 32'(O_BUSY), 32'd0);
    exp_q.push_back(CSpawn);
    I_RESET = 1'b1;
    wait_idle("spawn_after_reset", 60);

    // Gravity period per level: silent for period-1 ticks, GRAVITY on the next
    for (int i = 0; i < 6; i++) begin
      I_LEVEL = vecs[i].level;
      repeat (vecs[i].period - 1) tick();
      exp_q.push_back(CGrav);
      tick();
      wait_idle("gravity_period", 60);
    end
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(CGrav);
      tick();
      wait_idle("gravity_level15", 60);
    end
    I_LEVEL = 4'd0;

    // Priority: edges gathered while RIGHT is outstanding
    hold_done = 1'b1;
    exp_q.push_back(CRight);
    I_KEY_RIGHT = 1'b1;
    wait_empty("right_issued", 30);
    I_KEY_RIGHT = 1'b0;
    repeat (4) step();
    I_KEY_UP = 1'b1;  I_KEY_LEFT = 1'b1;  I_KEY_DOWN = 1'b1;
    repeat (6) step();
    exp_q.push_back(CRot);
    exp_q.push_back(CLeft);
    exp_q.push_back(CSoft);
    hold_done = 1'b0;
    wait_idle("priority_order", 80);
    I_KEY_UP = 1'b0;  I_KEY_LEFT = 1'b0;  I_KEY_DOWN = 1'b0;
    repeat (4) step();

    // Auto-repeat: edge, then frames 16, 20, 24, 28
    exp_q.push_back(CLeft);
    I_KEY_LEFT = 1'b1;
    wait_idle("left_edge", 40);
    for (int f = 1; f <= 30; f++) begin
      if (f == 16 || f == 20 || f == 24 || f == 28) exp_q.push_back(CLeft);
      tick();
    end
    wait_idle("left_repeat", 40);
    I_KEY_LEFT = 1'b0;
    repeat (4) step();

    // LEFT and RIGHT together: no shifts at all
    I_KEY_LEFT = 1'b1;  I_KEY_RIGHT = 1'b1;
    repeat (10) tick();
    wait_idle("both_held_quiet", 10);
    I_KEY_LEFT = 1'b0;  I_KEY_RIGHT = 1'b0;
    repeat (4) step();

    // Blocked gravity (48th frame since the soft drop) -> LOCK, SPAWN; pending ROT is dropped
    repeat (7) tick();
    hold_done = 1'b1;
    block_mask[CGrav] = 1'b1;
    exp_q.push_back(CGrav);
    tick();
    wait_empty("gravity_48", 30);
    I_KEY_UP = 1'b1;
    repeat (5) step();
    I_KEY_UP = 1'b0;
    repeat (2) step();
    exp_q.push_back(CLock);
    exp_q.push_back(CSpawn);
    hold_done = 1'b0;
    wait_idle("lock_spawn", 80);
    repeat (20) step();
    check("no_cmd_after_lock", 32'(O_BUSY), 32'd0);
    block_mask = '0;

    // Blocked soft drop then blocked spawn -> game over
    block_mask[CSoft] = 1'b1;
    block_mask[CSpawn] = 1'b1;
    exp_q.push_back(CSoft);
    exp_q.push_back(CLock);
    exp_q.push_back(CSpawn);
    I_KEY_DOWN = 1'b1;
    for (int i = 0; i < 60; i++) begin
      step();
      if (O_GAME_OVER) break;
    end
    I_KEY_DOWN = 1'b0;
    check("game_over", 32'(O_GAME_OVER), 32'd1);
    check("over_busy", 32'(O_BUSY), 32'd0);
    check("over_queue", 32'(exp_q.size()), 32'd0);
    for (int f = 0; f < 100; f++) begin
      I_KEY_UP = ((f % 7) == 0);
      I_KEY_LEFT = ((f % 5) == 0);
      I_KEY_DOWN = ((f % 3) == 0);
      tick();
      if ((f % 10) == 9) check("over_quiet", 32'(O_CMD_VALID), 32'd0);
    end
    I_KEY_UP = 1'b0;  I_KEY_LEFT = 1'b0;  I_KEY_DOWN = 1'b0;
    check("over_sticky", 32'(O_GAME_OVER), 32'd1);

    // Reset out of game over
    I_RESET = 1'b0;
    block_mask = '0;
    repeat (3) step();
    check("rst2_over", 32'(O_GAME_OVER), 32'd0);
    check("rst2_valid", 32'(O_CMD_VALID), 32'd0);
    exp_q.push_back(CSpawn);
    I_RESET = 1'b1;
    wait_idle("spawn_after_over", 60);

    // Reset while ROTATE is outstanding; stale DONE lands after reset release
    hold_done = 1'b1;
    exp_q.push_back(CRot);
    I_KEY_UP = 1'b1;
    wait_empty("rot_issued", 30);
    I_KEY_UP = 1'b0;
    repeat (2) step();
    check("busy_in_wait", 32'(O_BUSY), 32'd1);
    I_RESET = 1'b0;
    repeat (3) step();
    check("midrst_valid", 32'(O_CMD_VALID), 32'd0);
    check("midrst_busy", 32'(O_BUSY), 32'd0);
    check("midrst_cmd", 32'(O_CMD), 32'd0);
    exp_q.push_back(CSpawn);
    I_RESET = 1'b1;
    hold_done = 1'b0;
    wait_idle("spawn_after_midrst", 60);
    repeat (20) step();
    check("midrst_queue", 32'(exp_q.size()), 32'd0);
    check("midrst_over", 32'(O_GAME_OVER), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
